stack_sequencer: RTL

- Instruction-level controller for the stack CPU datapath.
- Accepts one stack instruction per valid/ready handshake: PUSH, POP, NOP, or ALU op.
- Owns a DEPTH-entry operand stack and the 8-function ALU. Sequences pop-operand, execute and push-result as a multi-cycle FSM.
- Checks overflow/underflow before any stack change and flags errors. Sits between the instruction source and the stack/ALU datapath.

---
 rtl/stack_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/stack_sequencer.sv
// Stack CPU instruction sequencer: operand stack, ALU, and the pop/exec/push FSM.
// Latency: PUSH/POP 1 working cycle, unary ALU 3, binary ALU 4, NOP/illegal 0; done follows in the next IDLE cycle.
// Backpressure: instr_ready is high only in IDLE; the source holds the instruction until it is accepted.
module stack_sequencer #(
  parameter int WORD  = 4,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [1:0]      instr_op,
  input  logic [2:0]      instr_alu,
  input  logic [WORD-1:0] instr_imm,
  output logic [WORD-1:0] top,
  output logic [CW-1:0]   depth,
  output logic            busy,
  output logic            done,
  output logic            err,
  input  logic            err_clr
);

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_ALU  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP_B,
    S_POP_A,
    S_EXEC,
    S_PUSH_R
  } state_t;

  state_t            state_q, state_d;
  logic [WORD-1:0]   stk_q [DEPTH];
  logic [WORD-1:0]   stk_d [DEPTH];
  logic [CW-1:0]     depth_q, depth_d;
  logic [WORD-1:0]   a_q, a_d;
  logic [WORD-1:0]   b_q, b_d;
  logic [WORD-1:0]   r_q, r_d;
  logic [1:0]        op_q, op_d;
  logic [2:0]        alu_q, alu_d;
  logic [WORD-1:0]   imm_q, imm_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept;
  logic              legal;
  logic              err_set;

  // Functions 3, 6 and 7 only consume the top entry (B).
  function automatic logic is_unary(input logic [2:0] f);
    return (f == 3'd3) || (f == 3'd6) || (f == 3'd7);
  endfunction

  // A is the deeper operand, B the former top; results wrap mod 2^WORD.
  function automatic logic [WORD-1:0] alu_fn(input logic [WORD-1:0] a,
                                             input logic [WORD-1:0] b,
                                             input logic [2:0]      f);
    logic [WORD-1:0] res;
    case (f)
      3'd0:    res = a ^ b;
      3'd1:    res = a | b;
      3'd2:    res = a & b;
      3'd3:    res = ~b;
      3'd4:    res = a + b;
      3'd5:    res = a - b;
      3'd6:    res = b;
      default: res = '0 - b;
    endcase
    return res;
  endfunction

  assign instr_ready = (state_q == S_IDLE) && !rst;
  assign accept      = instr_valid && instr_ready;
  assign top         = stk_q[0];
  assign depth       = depth_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign err         = err_q;

  // Legality of the presented instruction against the current stack depth.
  always_comb begin
    legal = 1'b1;
    case (instr_op)
      OP_PUSH: legal = (depth_q < CW'(DEPTH));
      OP_POP:  legal = (depth_q != '0);
      OP_ALU:  legal = is_unary(instr_alu) ? (depth_q != '0) : (depth_q >= CW'(2));
      default: legal = 1'b1;
    endcase
  end

  // Next-state logic: FSM transitions, stack shifts, operand capture, done/err.
  always_comb begin
    state_d = state_q;
    stk_d   = stk_q;
    depth_d = depth_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    op_d    = op_q;
    alu_d   = alu_q;
    imm_d   = imm_q;
    done_d  = 1'b0;
    err_set = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = instr_op;
          alu_d = instr_alu;
          imm_d = instr_imm;
          if (!legal) begin
            err_set = 1'b1;
            done_d  = 1'b1;
          end else begin
            case (instr_op)
              OP_PUSH: state_d = S_PUSH_R;
              OP_POP:  state_d = S_POP_B;
              OP_ALU:  state_d = S_POP_B;
              default: done_d  = 1'b1;
            endcase
          end
        end
      end
      S_POP_B, S_POP_A: begin
        if (state_q == S_POP_B) b_d = stk_q[0];
        else                    a_d = stk_q[0];
        for (int i = 0; i < DEPTH - 1; i++) stk_d[i] = stk_q[i+1];
        stk_d[DEPTH-1] = '0;
        depth_d = depth_q - CW'(1);
        if (state_q == S_POP_A) begin
          state_d = S_EXEC;
        end else if (op_q == OP_POP) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (is_unary(alu_q)) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_POP_A;
        end
      end
      S_EXEC: begin
        r_d     = alu_fn(a_q, b_q, alu_q);
        state_d = S_PUSH_R;
      end
      S_PUSH_R: begin
        for (int i = DEPTH - 1; i > 0; i--) stk_d[i] = stk_q[i-1];
        stk_d[0] = (op_q == OP_ALU) ? r_q : imm_q;
        depth_d  = depth_q + CW'(1);
        state_d  = S_IDLE;
        done_d   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Setting wins over a simultaneous clear.
    if (err_set)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;
  end

  // State register with asynchronous reset of every stack entry and operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
      depth_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      op_q    <= OP_NOP;
      alu_q   <= '0;
      imm_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stk_q   <= stk_d;
      depth_q <= depth_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      op_q    <= op_d;
      alu_q   <= alu_d;
      imm_q   <= imm_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule
